sm4_axis8_arbiter: RTL and testbench

Two-requester round-robin scheduler that shares one `sm4_top_axis8_padding` engine between two independent 8-bit AXI-Stream packet sources, each carrying its own key and encrypt/decrypt select. It grants whole packets, drains the engine and issues a `sm4_vld` key-load pulse whenever the granted requester's configuration differs from the one currently loaded, and demultiplexes engine output back to per-requester output streams using `tuser[7]`.

---
 rtl/sm4_axis8_arbiter.sv | 274 +++++++++++++++++++++++++++
 tb/tb_sm4_axis8_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_axis8_arbiter.sv
// sm4_axis8_arbiter
// Round-robin scheduler that shares one SM4 AXI-Stream padding engine between
// two packet sources. Whole packets are granted. Before a packet whose
// {key,sel} differs from the configuration loaded in the engine, the arbiter
// waits for all in-flight results to leave the engine. It then pulses
// e_sm4_vld and allows KEY_WAIT idle cycles for key expansion.
// Engine results are routed back to m0/m1 using e_m_axis_tuser[7].
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   sN_key, sN_sel       : requester N configuration (stable while tvalid)
//   sN_axis_*            : requester N input stream (tuser 7 bits)
//   mN_axis_*            : requester N result stream, registered, no backpressure
//   e_sm4_vld/key/sel    : key-load pulse and configuration to the engine
//   e_s_axis_*           : engine input stream, tuser = {grant, sN_axis_tuser}
//   e_m_axis_*           : engine output stream
module sm4_axis8_arbiter #(
  parameter int KEY_WAIT = 32,
  parameter int MAX_OUT  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] s0_key,
  input  logic         s0_sel,
  input  logic [7:0]   s0_axis_tdata,
  input  logic         s0_axis_tvalid,
  input  logic         s0_axis_tlast,
  input  logic [6:0]   s0_axis_tuser,
  output logic         s0_axis_tready,
  input  logic [127:0] s1_key,
  input  logic         s1_sel,
  input  logic [7:0]   s1_axis_tdata,
  input  logic         s1_axis_tvalid,
  input  logic         s1_axis_tlast,
  input  logic [6:0]   s1_axis_tuser,
  output logic         s1_axis_tready,
  output logic [7:0]   m0_axis_tdata,
  output logic         m0_axis_tvalid,
  output logic         m0_axis_tlast,
  output logic [6:0]   m0_axis_tuser,
  output logic [7:0]   m1_axis_tdata,
  output logic         m1_axis_tvalid,
  output logic         m1_axis_tlast,
  output logic [6:0]   m1_axis_tuser,
  output logic         e_sm4_vld,
  output logic [127:0] e_sm4_key,
  output logic         e_sm4_sel,
  output logic [7:0]   e_s_axis_tdata,
  output logic         e_s_axis_tvalid,
  output logic         e_s_axis_tlast,
  output logic [7:0]   e_s_axis_tuser,
  input  logic         e_s_axis_tready,
  input  logic [7:0]   e_m_axis_tdata,
  input  logic         e_m_axis_tvalid,
  input  logic         e_m_axis_tlast,
  input  logic [7:0]   e_m_axis_tuser
);

  // The wait counter holds KEY_WAIT-1 down to 0.
  localparam int CNT_W = (KEY_WAIT > 1) ? $clog2(KEY_WAIT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_XFER  = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic               grant_r, last_grant_r;
  logic [127:0]       cfg_key_r, loaded_key_r;
  logic               cfg_sel_r, loaded_sel_r, loaded_valid_r;
  logic               vld_r;
  logic [CNT_W-1:0]   wait_cnt_r;
  logic [3:0]         outstanding_r;

  logic               pick_s, cfg_match_s, full_s;
  logic [127:0]       pick_key_s;
  logic               pick_sel_s;
  logic [7:0]         g_tdata_s;
  logic               g_tvalid_s, g_tlast_s;
  logic [6:0]         g_tuser_s;
  logic               in_last_s, out_dec_s, m_sel0_s, m_sel1_s;

  // Candidate grant for the next packet: the one not served last wins a tie.
  always_comb begin
    pick_s = 1'b0;
    if (s0_axis_tvalid && s1_axis_tvalid) begin
      pick_s = ~last_grant_r;
    end else if (s1_axis_tvalid) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    pick_key_s  = pick_s ? s1_key : s0_key;
    pick_sel_s  = pick_s ? s1_sel : s0_sel;
    cfg_match_s = loaded_valid_r && (pick_key_s == loaded_key_r) && (pick_sel_s == loaded_sel_r);
    full_s      = (outstanding_r == 4'(MAX_OUT));
  end

  // Stream of the currently granted requester.
  always_comb begin
    if (grant_r) begin
      g_tdata_s  = s1_axis_tdata;
      g_tvalid_s = s1_axis_tvalid;
      g_tlast_s  = s1_axis_tlast;
      g_tuser_s  = s1_axis_tuser;
    end else begin
      g_tdata_s  = s0_axis_tdata;
      g_tvalid_s = s0_axis_tvalid;
      g_tlast_s  = s0_axis_tlast;
      g_tuser_s  = s0_axis_tuser;
    end
    in_last_s = (state_r == ST_XFER) && g_tvalid_s && e_s_axis_tready && g_tlast_s;
    // An output tlast with nothing outstanding is an engine fault; ignore it.
    out_dec_s = e_m_axis_tvalid && e_m_axis_tlast && (outstanding_r != 4'd0);
    m_sel0_s  = e_m_axis_tvalid && !e_m_axis_tuser[7];
    m_sel1_s  = e_m_axis_tvalid && e_m_axis_tuser[7];
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if ((!s0_axis_tvalid && !s1_axis_tvalid) || full_s) begin
          state_s = ST_IDLE;
        end else if (cfg_match_s) begin
          state_s = ST_XFER;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outstanding_r == 4'd0) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_LOAD: state_s = ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_XFER;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_XFER: begin
        if (in_last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_XFER;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM state, grant/configuration registers, key-load pulse and wait counter.
  // The loaded configuration is updated on entry to LOAD so that e_sm4_key
  // carries the new key during the pulse and holds it afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      grant_r        <= 1'b0;
      last_grant_r   <= 1'b1;
      cfg_key_r      <= 128'd0;
      cfg_sel_r      <= 1'b0;
      loaded_key_r   <= 128'd0;
      loaded_sel_r   <= 1'b0;
      loaded_valid_r <= 1'b0;
      vld_r          <= 1'b0;
      wait_cnt_r     <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_IDLE: begin
          if (state_s != ST_IDLE) begin
            grant_r   <= pick_s;
            cfg_key_r <= pick_key_s;
            cfg_sel_r <= pick_sel_s;
          end
        end
        ST_DRAIN: begin
          if (state_s == ST_LOAD) begin
            loaded_key_r   <= cfg_key_r;
            loaded_sel_r   <= cfg_sel_r;
            loaded_valid_r <= 1'b1;
            vld_r          <= 1'b1;
          end
        end
        ST_LOAD: begin
          vld_r      <= 1'b0;
          wait_cnt_r <= CNT_W'(KEY_WAIT - 1);
        end
        ST_WAIT: begin
          if (wait_cnt_r != {CNT_W{1'b0}}) begin
            wait_cnt_r <= wait_cnt_r - CNT_W'(1);
          end
        end
        ST_XFER: begin
          if (in_last_s) begin
            last_grant_r <= grant_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Count of packets inside the engine whose output tlast is still pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_r <= 4'd0;
    end else begin
      case ({in_last_s, out_dec_s})
        2'b10:   outstanding_r <= outstanding_r + 4'd1;
        2'b01:   outstanding_r <= outstanding_r - 4'd1;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Engine input path: pass-through of the granted stream during XFER only.
  always_comb begin
    e_s_axis_tdata  = 8'd0;
    e_s_axis_tvalid = 1'b0;
    e_s_axis_tlast  = 1'b0;
    e_s_axis_tuser  = 8'd0;
    s0_axis_tready  = 1'b0;
    s1_axis_tready  = 1'b0;
    if (state_r == ST_XFER) begin
      e_s_axis_tdata  = g_tdata_s;
      e_s_axis_tvalid = g_tvalid_s;
      e_s_axis_tlast  = g_tlast_s;
      e_s_axis_tuser  = {grant_r, g_tuser_s};
      s0_axis_tready  = ~grant_r & e_s_axis_tready;
      s1_axis_tready  = grant_r & e_s_axis_tready;
    end else begin
      e_s_axis_tvalid = 1'b0;
    end
  end

  assign e_sm4_vld = vld_r;
  assign e_sm4_key = loaded_key_r;
  assign e_sm4_sel = loaded_sel_r;

  // Output demux: registered copy of the engine result on the selected port.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_axis_tdata  <= 8'd0;
      m0_axis_tvalid <= 1'b0;
      m0_axis_tlast  <= 1'b0;
      m0_axis_tuser  <= 7'd0;
      m1_axis_tdata  <= 8'd0;
      m1_axis_tvalid <= 1'b0;
      m1_axis_tlast  <= 1'b0;
      m1_axis_tuser  <= 7'd0;
    end else begin
      m0_axis_tvalid <= m_sel0_s;
      m0_axis_tdata  <= m_sel0_s ? e_m_axis_tdata : 8'd0;
      m0_axis_tlast  <= m_sel0_s & e_m_axis_tlast;
      m0_axis_tuser  <= m_sel0_s ? e_m_axis_tuser[6:0] : 7'd0;
      m1_axis_tvalid <= m_sel1_s;
      m1_axis_tdata  <= m_sel1_s ? e_m_axis_tdata : 8'd0;
      m1_axis_tlast  <= m_sel1_s & e_m_axis_tlast;
      m1_axis_tuser  <= m_sel1_s ? e_m_axis_tuser[6:0] : 7'd0;
    end
  end

endmodule

// File: tb/tb_sm4_axis8_arbiter.sv
// Directed bench for sm4_axis8_arbiter; the bench plays both requesters and
// the SM4 engine (input ready and result stream).
module tb_sm4_axis8_arbiter;

  localparam int KW = 32;

  logic clk, rst;
  logic [127:0] s0_key, s1_key;
  logic s0_sel, s1_sel;
  logic [7:0] s0_axis_tdata, s1_axis_tdata;
  logic s0_axis_tvalid, s0_axis_tlast, s1_axis_tvalid, s1_axis_tlast;
  logic [6:0] s0_axis_tuser, s1_axis_tuser;
  logic s0_axis_tready, s1_axis_tready;
  logic [7:0] m0_axis_tdata, m1_axis_tdata;
  logic m0_axis_tvalid, m0_axis_tlast, m1_axis_tvalid, m1_axis_tlast;
  logic [6:0] m0_axis_tuser, m1_axis_tuser;
  logic e_sm4_vld, e_sm4_sel;
  logic [127:0] e_sm4_key;
  logic [7:0] e_s_axis_tdata, e_s_axis_tuser;
  logic e_s_axis_tvalid, e_s_axis_tlast, e_s_axis_tready;
  logic [7:0] e_m_axis_tdata, e_m_axis_tuser;
  logic e_m_axis_tvalid, e_m_axis_tlast;

  sm4_axis8_arbiter #(.KEY_WAIT(KW), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst),
    .s0_key(s0_key), .s0_sel(s0_sel), .s0_axis_tdata(s0_axis_tdata),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast),
    .s0_axis_tuser(s0_axis_tuser), .s0_axis_tready(s0_axis_tready),
    .s1_key(s1_key), .s1_sel(s1_sel), .s1_axis_tdata(s1_axis_tdata),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast),
    .s1_axis_tuser(s1_axis_tuser), .s1_axis_tready(s1_axis_tready),
    .m0_axis_tdata(m0_axis_tdata), .m0_axis_tvalid(m0_axis_tvalid),
    .m0_axis_tlast(m0_axis_tlast), .m0_axis_tuser(m0_axis_tuser),
    .m1_axis_tdata(m1_axis_tdata), .m1_axis_tvalid(m1_axis_tvalid),
    .m1_axis_tlast(m1_axis_tlast), .m1_axis_tuser(m1_axis_tuser),
    .e_sm4_vld(e_sm4_vld), .e_sm4_key(e_sm4_key), .e_sm4_sel(e_sm4_sel),
    .e_s_axis_tdata(e_s_axis_tdata), .e_s_axis_tvalid(e_s_axis_tvalid),
    .e_s_axis_tlast(e_s_axis_tlast), .e_s_axis_tuser(e_s_axis_tuser),
    .e_s_axis_tready(e_s_axis_tready),
    .e_m_axis_tdata(e_m_axis_tdata), .e_m_axis_tvalid(e_m_axis_tvalid),
    .e_m_axis_tlast(e_m_axis_tlast), .e_m_axis_tuser(e_m_axis_tuser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int vld_cnt = 0;
  int vld_cyc = 0;
  logic [127:0] vld_key = 128'd0;
  logic vld_sel = 1'b0;
  int in_cnt = 0;
  logic glog [0:63];

  // Edge monitor: cycle count, key-load pulses and input tlast handshakes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (e_sm4_vld) begin
      vld_cnt <= vld_cnt + 1;
      vld_cyc <= cyc + 1;
      vld_key <= e_sm4_key;
      vld_sel <= e_sm4_sel;
    end
    if (e_s_axis_tvalid && e_s_axis_tready && e_s_axis_tlast && in_cnt < 64) begin
      in_cnt <= in_cnt + 1;
      glog[in_cnt] <= e_s_axis_tuser[7];
    end
  end

  task automatic chk_k(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int p, input logic v, input logic [7:0] d, input logic l,
                         input logic [6:0] u, input logic [127:0] k, input logic s);
    if (p == 0) begin
      s0_axis_tvalid = v; s0_axis_tdata = d; s0_axis_tlast = l;
      s0_axis_tuser = u; s0_key = k; s0_sel = s;
    end else begin
      s1_axis_tvalid = v; s1_axis_tdata = d; s1_axis_tlast = l;
      s1_axis_tuser = u; s1_key = k; s1_sel = s;
    end
  endtask

  // Offer an n-byte packet on port p; idle_cyc is the edge where the arbiter
  // first samples tvalid, first_cyc the edge accepting byte 0.
  task automatic send_pkt(input int p, input logic [127:0] k, input logic s, input int n,
                          input logic [6:0] u, input logic [7:0] base, input int budget,
                          output int idle_cyc, output int first_cyc, output logic ok);
    int i;
    int t;
    logic hs;
    i = 0; t = 0;
    idle_cyc = cyc + 1;
    first_cyc = -1;
    set_src(p, 1'b1, base, n == 1, u, k, s);
    while (i < n && t < budget) begin
      #1;
      hs = (p == 0) ? s0_axis_tready : s1_axis_tready;
      @(posedge clk); #1;
      t++;
      if (hs) begin
        if (i == 0) first_cyc = cyc;
        i++;
        set_src(p, i < n, base + 8'(i), i == n - 1, u, k, s);
      end
    end
    set_src(p, 1'b0, 8'd0, 1'b0, u, k, s);
    ok = (i == n);
  endtask

  // Engine emits one result byte; the registered demux is checked one edge later.
  task automatic emit(input logic [7:0] d, input logic l, input logic [7:0] u, output int e_cyc);
    e_m_axis_tdata = d; e_m_axis_tvalid = 1'b1; e_m_axis_tlast = l; e_m_axis_tuser = u;
    @(posedge clk); #1;
    e_cyc = cyc;
    e_m_axis_tdata = 8'd0; e_m_axis_tvalid = 1'b0; e_m_axis_tlast = 1'b0; e_m_axis_tuser = 8'd0;
    chk_i("demux_valid", int'({m1_axis_tvalid, m0_axis_tvalid}), u[7] ? 2 : 1);
    chk_i("demux_data", int'(u[7] ? m1_axis_tdata : m0_axis_tdata), int'(d));
    chk_i("demux_last", int'(u[7] ? m1_axis_tlast : m0_axis_tlast), int'(l));
    chk_i("demux_user", int'(u[7] ? m1_axis_tuser : m0_axis_tuser), int'(u[6:0]));
  endtask

  task automatic outs_zero(input string tag);
    chk_i({tag, "_tready0"}, int'(s0_axis_tready), 0);
    chk_i({tag, "_tready1"}, int'(s1_axis_tready), 0);
    chk_i({tag, "_es_valid"}, int'(e_s_axis_tvalid), 0);
    chk_i({tag, "_es_data"}, int'(e_s_axis_tdata), 0);
    chk_i({tag, "_es_user"}, int'(e_s_axis_tuser), 0);
    chk_i({tag, "_vld"}, int'(e_sm4_vld), 0);
    chk_k({tag, "_key"}, e_sm4_key, 128'd0);
    chk_i({tag, "_sel"}, int'(e_sm4_sel), 0);
    chk_i({tag, "_m_valid"}, int'({m1_axis_tvalid, m0_axis_tvalid}), 0);
  endtask

  task automatic do_reset();
    set_src(0, 1'b0, 8'd0, 1'b0, 7'd0, 128'd0, 1'b0);
    set_src(1, 1'b0, 8'd0, 1'b0, 7'd0, 128'd0, 1'b0);
    e_m_axis_tdata = 8'd0; e_m_axis_tvalid = 1'b0; e_m_axis_tlast = 1'b0; e_m_axis_tuser = 8'd0;
    e_s_axis_tready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    outs_zero("reset");
    rst = 1'b0;
  endtask

  localparam logic [127:0] K0 = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] K1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;

  int ia, fa, ib, fb, e0, e1, e2, e3, v0, in0, nacc, tt;
  logic oka, okb, hs;
  logic [127:0] ct_r;

  initial begin
    rst = 1'b1;
    do_reset();

    // 1: first packet loads the key, 35 cycles from grant to first byte
    v0 = vld_cnt;
    send_pkt(0, K0, 1'b0, 16, 7'h15, 8'h00, 200, ia, fa, oka);
    chk_i("t1_ok", int'(oka), 1);
    chk_i("t1_vld_count", vld_cnt - v0, 1);
    chk_k("t1_vld_key", vld_key, K0);
    chk_i("t1_vld_sel", int'(vld_sel), 0);
    chk_i("t1_vld_time", vld_cyc - ia, 2);
    chk_i("t1_first_byte", fa - ia, KW + 3);
    chk_k("t1_key_hold", e_sm4_key, K0);
    ct_r = CT;
    for (int i = 0; i < 32; i++) begin
      emit((i < 16) ? ct_r[127 - 8*i -: 8] : 8'hA0 + 8'(i), i == 31, {1'b0, 7'h15}, e0);
    end
    @(posedge clk); #1;
    chk_i("t1_m0_idle", int'(m0_axis_tvalid), 0);

    // 2: two more packets with the same key: no reload, one-cycle grant
    v0 = vld_cnt;
    send_pkt(0, K0, 1'b0, 4, 7'h16, 8'h30, 50, ia, fa, oka);
    chk_i("t2a_gap", fa - ia, 1);
    send_pkt(0, K0, 1'b0, 4, 7'h17, 8'h40, 50, ia, fa, oka);
    chk_i("t2b_gap", fa - ia, 1);
    chk_i("t2_no_reload", vld_cnt - v0, 0);

    // 3: simultaneous requests, different keys: s0 first, drain, reload for s1
    do_reset();
    v0 = vld_cnt; in0 = in_cnt;
    fork
      send_pkt(0, K0, 1'b0, 4, 7'h11, 8'h10, 300, ia, fa, oka);
      send_pkt(1, K1, 1'b1, 4, 7'h22, 8'h20, 300, ib, fb, okb);
      begin : eng3
        int t;
        t = 0;
        while (in_cnt == in0 && t < 200) begin @(posedge clk); #1; t++; end
        repeat (3) @(posedge clk);
        #1;
        emit(8'h55, 1'b1, {1'b0, 7'h11}, e0);
      end
    join
    chk_i("t3_ok", int'({oka, okb}), 3);
    chk_i("t3_order0", int'(glog[in0]), 0);
    chk_i("t3_order1", int'(glog[in0 + 1]), 1);
    chk_i("t3_vld_count", vld_cnt - v0, 2);
    chk_k("t3_vld_key", vld_key, K1);
    chk_i("t3_vld_sel", int'(vld_sel), 1);
    chk_i("t3_vld_after_drain", vld_cyc - e0, 2);
    chk_i("t3_s1_first", fb - e0, KW + 3);
    emit(8'h66, 1'b1, {1'b1, 7'h22}, e1);

    // 4: same key on both: one load, grants alternate 0,1,0,1
    do_reset();
    v0 = vld_cnt; in0 = in_cnt;
    fork
      begin
        send_pkt(0, K0, 1'b0, 2, 7'h01, 8'h80, 300, ia, fa, oka);
        send_pkt(0, K0, 1'b0, 2, 7'h02, 8'h82, 300, ia, fa, oka);
      end
      begin
        send_pkt(1, K0, 1'b0, 2, 7'h03, 8'h90, 300, ib, fb, okb);
        send_pkt(1, K0, 1'b0, 2, 7'h04, 8'h92, 300, ib, fb, okb);
      end
      begin : eng4
        int t;
        for (int k = 0; k < 4; k++) begin
          t = 0;
          while (in_cnt <= in0 + k && t < 300) begin @(posedge clk); #1; t++; end
          repeat (2) @(posedge clk);
          #1;
          emit(8'h70 + 8'(k), 1'b1, {glog[in0 + k], 7'(k)}, e0);
        end
      end
    join
    chk_i("t4_ok", int'({oka, okb}), 3);
    chk_i("t4_grants", int'({glog[in0], glog[in0+1], glog[in0+2], glog[in0+3]}), 5);
    chk_i("t4_vld_count", vld_cnt - v0, 1);

    // 5: results stalled, MAX_OUT=2
    do_reset();
    send_pkt(0, K0, 1'b0, 1, 7'h05, 8'h50, 100, ia, fa, oka);
    chk_i("t5_p1", int'(oka), 1);
    send_pkt(0, K0, 1'b0, 1, 7'h05, 8'h51, 100, ia, fa, oka);
    chk_i("t5_p2", int'(oka), 1);
    send_pkt(0, K0, 1'b0, 1, 7'h05, 8'h52, 15, ia, fa, oka);
    chk_i("t5_p3_blocked", int'(oka), 0);
    fork
      send_pkt(0, K0, 1'b0, 1, 7'h05, 8'h52, 100, ia, fa, oka);
      begin repeat (5) @(posedge clk); #1; emit(8'hC0, 1'b1, 8'h05, e1); end
    join
    chk_i("t5_p3_ok", int'(oka), 1);
    chk_i("t5_p3_release", fa - e1, 2);
    fork
      send_pkt(0, K0, 1'b0, 1, 7'h05, 8'h53, 100, ia, fa, oka);
      begin
        repeat (5) @(posedge clk);
        #1;
        emit(8'hC1, 1'b1, 8'h05, e2);
        @(posedge clk); #1;
        emit(8'hC2, 1'b1, 8'h05, e3);
      end
    join
    chk_i("t5_p4_release", fa - e2, 2);
    chk_i("t5_p4_simul", fa, e3);
    send_pkt(0, K0, 1'b0, 1, 7'h05, 8'h54, 10, ia, fa, oka);
    chk_i("t5_p5_granted", int'(oka), 1);
    send_pkt(0, K0, 1'b0, 1, 7'h05, 8'h55, 15, ia, fa, oka);
    chk_i("t5_p6_blocked", int'(oka), 0);

    // 6: reset during byte 5 of a packet, then the same key reloads
    do_reset();
    v0 = vld_cnt;
    set_src(0, 1'b1, 8'h60, 1'b0, 7'h06, K0, 1'b0);
    nacc = 0; tt = 0;
    while (nacc < 4 && tt < 200) begin
      #1;
      hs = s0_axis_tready;
      @(posedge clk); #1;
      tt++;
      if (hs) begin
        nacc++;
        set_src(0, 1'b1, 8'h60 + 8'(nacc), 1'b0, 7'h06, K0, 1'b0);
      end
    end
    chk_i("t6_reach_byte5", nacc, 4);
    chk_i("t6_byte5_ready", int'(s0_axis_tready), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    outs_zero("t6_rst");
    rst = 1'b0;
    set_src(0, 1'b0, 8'd0, 1'b0, 7'h06, K0, 1'b0);
    chk_i("t6_first_load", vld_cnt - v0, 1);
    v0 = vld_cnt;
    send_pkt(0, K0, 1'b0, 2, 7'h07, 8'h68, 100, ia, fa, oka);
    chk_i("t6_ok", int'(oka), 1);
    chk_i("t6_reload", vld_cnt - v0, 1);
    chk_k("t6_reload_key", vld_key, K0);
    chk_i("t6_first_byte", fa - ia, KW + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
